// File: rtl/fft_output_reorder.sv
// fft_output_reorder
// Collects 64-point FFT frames that arrive in bit-reversed bin order and
// replays them in natural bin order (0..D_WIDTH-1) over a valid/ready stream.
// Build option: define REORDER_PINGPONG_EN for two banks, which overlaps fill
// and drain for full throughput. Without it there is a single bank, and fill
// and drain alternate.
module fft_output_reorder #(
    parameter int unsigned D_WIDTH     = 64,
    parameter int unsigned LOG_2_WIDTH = 6,
    parameter int unsigned S_WIDTH     = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [S_WIDTH-1:0]     in_re,
    input  logic [S_WIDTH-1:0]     in_im,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [S_WIDTH-1:0]     out_re,
    output logic [S_WIDTH-1:0]     out_im,
    output logic [LOG_2_WIDTH-1:0] out_index,
    output logic                   out_last
);

`ifdef REORDER_PINGPONG_EN
    localparam int unsigned NB = 2;
`else
    localparam int unsigned NB = 1;
`endif

    localparam logic [LOG_2_WIDTH-1:0] LAST_IDX = LOG_2_WIDTH'(D_WIDTH - 1);

    typedef enum logic [1:0] {
        EMPTY,
        FILLING,
        FULL,
        DRAINING
    } bank_state_t;

    bank_state_t            bank_state [NB];
    logic                   wr_bank;
    logic                   rd_bank;
    logic [LOG_2_WIDTH-1:0] wr_cnt;
    logic [LOG_2_WIDTH-1:0] rd_cnt;
    logic [S_WIDTH-1:0]     mem_re [NB][D_WIDTH];
    logic [S_WIDTH-1:0]     mem_im [NB][D_WIDTH];
    logic                   in_acc;
    logic                   out_acc;

    function automatic logic [LOG_2_WIDTH-1:0] bitrev(input logic [LOG_2_WIDTH-1:0] a);
        return {<<{a}};
    endfunction

    assign in_ready  = (bank_state[wr_bank] == EMPTY) || (bank_state[wr_bank] == FILLING);
    assign out_valid = (bank_state[rd_bank] == FULL) || (bank_state[rd_bank] == DRAINING);
    assign out_re    = mem_re[rd_bank][rd_cnt];
    assign out_im    = mem_im[rd_bank][rd_cnt];
    assign out_index = rd_cnt;
    assign out_last  = out_valid && (rd_cnt == LAST_IDX);

    assign in_acc  = in_valid && in_ready;
    assign out_acc = out_valid && out_ready;

    // Bank state machine, write/read counters and bank pointers.
    // Write and read never touch the same bank in one cycle: a write needs
    // EMPTY/FILLING and a read needs FULL/DRAINING.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_state <= '{default: EMPTY};
            wr_bank    <= 1'b0;
            rd_bank    <= 1'b0;
            wr_cnt     <= '0;
            rd_cnt     <= '0;
        end else begin
            if (in_acc) begin
                if (wr_cnt == LAST_IDX) begin
                    bank_state[wr_bank] <= FULL;
                    wr_cnt              <= '0;
                    wr_bank             <= (NB > 1) ? ~wr_bank : 1'b0;
                end else begin
                    bank_state[wr_bank] <= FILLING;
                    wr_cnt              <= wr_cnt + 1'b1;
                end
            end
            if (out_acc) begin
                if (rd_cnt == LAST_IDX) begin
                    bank_state[rd_bank] <= EMPTY;
                    rd_cnt              <= '0;
                    rd_bank             <= (NB > 1) ? ~rd_bank : 1'b0;
                end else begin
                    bank_state[rd_bank] <= DRAINING;
                    rd_cnt              <= rd_cnt + 1'b1;
                end
            end
        end
    end

    // Sample storage: each accepted input lands at its natural bin address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_re <= '{default: '0};
            mem_im <= '{default: '0};
        end else if (in_acc) begin
            mem_re[wr_bank][bitrev(wr_cnt)] <= in_re;
            mem_im[wr_bank][bitrev(wr_cnt)] <= in_im;
        end
    end

endmodule

// File: tb/tb_fft_output_reorder.sv
// Testbench for fft_output_reorder. Follows the REORDER_PINGPONG_EN build
// option to select capacity and throughput expectations.
module tb_fft_output_reorder;

`ifdef REORDER_PINGPONG_EN
    localparam int unsigned CAP = 128;
    localparam bit          PP  = 1'b1;
`else
    localparam int unsigned CAP = 64;
    localparam bit          PP  = 1'b0;
`endif
    localparam int unsigned LIMIT = 3000;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_re;
    logic [15:0] in_im;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_re;
    logic [15:0] out_im;
    logic [5:0]  out_index;
    logic        out_last;

    fft_output_reorder #(
        .D_WIDTH(64),
        .LOG_2_WIDTH(6),
        .S_WIDTH(16)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_re(in_re),
        .in_im(in_im),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_re(out_re),
        .out_im(out_im),
        .out_index(out_index),
        .out_last(out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] re;
        logic [15:0] im;
        logic [5:0]  idx;
    } exp_t;

    exp_t        sb [$];
    exp_t        e;
    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    int unsigned in_cnt = 0;
    bit          rand_out = 1'b0;
    bit          hold_prev = 1'b0;
    logic [15:0] prev_re;
    logic [15:0] prev_im;
    logic [5:0]  prev_idx;
    bit          gap_watch = 1'b0;
    int unsigned out_seen = 0;
    int unsigned gap_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [5:0] bitrev6(input logic [5:0] a);
        return {a[0], a[1], a[2], a[3], a[4], a[5]};
    endfunction

    // Sample c of frame "tag": upper bits carry the frame tag, low bits bitrev6(c).
    function automatic logic [15:0] mk(input int unsigned tag, input int unsigned c);
        logic [9:0] t;
        logic [5:0] cc;
        t  = tag[9:0];
        cc = c[5:0];
        return {t, bitrev6(cc)};
    endfunction

    // Scoreboard, stall-stability and gap monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (gap_watch && out_seen > 0 && out_seen < 256 && !out_valid)
                gap_cnt++;
            if (hold_prev) begin
                check("hold_re", out_re, prev_re);
                check("hold_im", out_im, prev_im);
                check("hold_index", out_index, prev_idx);
            end
            hold_prev = out_valid && !out_ready;
            prev_re   = out_re;
            prev_im   = out_im;
            prev_idx  = out_index;
            if (out_valid && out_ready) begin
                if (gap_watch) out_seen++;
                check("sb_nonempty", (sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("out_re", out_re, e.re);
                    check("out_im", out_im, e.im);
                    check("out_index", out_index, e.idx);
                    check("out_last", out_last, (e.idx == 6'd63));
                end
            end
            if (in_valid && in_ready) begin
                in_cnt++;
                if (in_cnt == 64) begin
                    in_cnt = 0;
                    for (int unsigned k = 0; k < 64; k++) begin
                        exp_t x;
                        x.re  = {in_re[15:6], k[5:0]};
                        x.im  = ~{in_re[15:6], k[5:0]};
                        x.idx = k[5:0];
                        sb.push_back(x);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_out) out_ready = 1'($urandom_range(1));
    endtask

    task automatic drive_frame(input int unsigned tag, input int unsigned pct,
                               output int unsigned low_cnt, output logic pre_valid);
        low_cnt   = 0;
        pre_valid = 1'b0;
        for (int unsigned c = 0; c < 64; c++) begin
            bit          done;
            int unsigned guard;
            done  = 1'b0;
            guard = 0;
            while (!done && guard < LIMIT) begin
                in_valid = ($urandom_range(99) < pct);
                in_re    = mk(tag, c);
                in_im    = ~mk(tag, c);
                @(negedge clk);
                if (in_valid && !in_ready) low_cnt++;
                done      = in_valid && in_ready;
                pre_valid = out_valid;
                tick();
                guard++;
            end
            check("in_accept_timeout", done, 1);
            if (!done) return;
        end
    endtask

    task automatic wait_drain(input string tag);
        int unsigned g;
        g = 0;
        while (sb.size() != 0 && g < LIMIT) begin
            tick();
            g++;
        end
        check(tag, sb.size(), 0);
        check("drained_out_valid", out_valid, 0);
    endtask

    task automatic check_reset_outputs();
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_re", out_re, 0);
        check("rst_out_im", out_im, 0);
        check("rst_out_index", out_index, 0);
        check("rst_out_last", out_last, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned low;
        int unsigned low_tot;
        int unsigned acc;
        logic        pre;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_re     = '0;
        in_im     = '0;
        out_ready = 1'b0;
        #12;
        check_reset_outputs();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single frame: first output 1 cycle after the 64th accept.
        out_ready = 1'b1;
        drive_frame(0, 100, low, pre);
        in_valid = 1'b0;
        check("lat_pre_valid", pre, 0);
        check("lat_valid", out_valid, 1);
        check("lat_index", out_index, 0);
        check("lat_re", out_re, 16'h0000);
        check("lat_im", out_im, 16'hffff);
        wait_drain("single_drain");

        // Back-to-back frames with continuous valid/ready.
        gap_watch = 1'b1;
        out_seen  = 0;
        gap_cnt   = 0;
        low_tot   = 0;
        for (int unsigned f = 1; f <= 4; f++) begin
            drive_frame(f, 100, low, pre);
            low_tot += low;
        end
        in_valid = 1'b0;
        wait_drain("b2b_drain");
        gap_watch = 1'b0;
        check("b2b_outputs", out_seen, 256);
        check("b2b_in_ready_low", low_tot, PP ? 0 : 192);
        check("b2b_out_gaps", gap_cnt, PP ? 0 : 192);

        // Output stall with 200 offered inputs.
        out_ready = 1'b0;
        acc = 0;
        for (int unsigned i = 0; i < 200; i++) begin
            in_valid = 1'b1;
            in_re    = mk(5 + acc / 64, acc % 64);
            in_im    = ~mk(5 + acc / 64, acc % 64);
            @(negedge clk);
            if (in_ready) acc++;
            tick();
        end
        in_valid = 1'b0;
        check("stall_accepted", acc, CAP);
        check("stall_in_ready", in_ready, 0);
        check("stall_out_valid", out_valid, 1);
        check("stall_out_index", out_index, 0);
        out_ready = 1'b1;
        wait_drain("stall_drain");

        // Random valid/ready at 50%.
        rand_out = 1'b1;
        for (int unsigned f = 0; f < 10; f++)
            drive_frame(10 + f, 50, low, pre);
        in_valid  = 1'b0;
        rand_out  = 1'b0;
        out_ready = 1'b1;
        wait_drain("random_drain");

        // Reset mid-frame discards full and partial frames.
        out_ready = 1'b0;
        drive_frame(30, 100, low, pre);
        for (int unsigned c = 0; c < 20; c++) begin
            in_valid = 1'b1;
            in_re    = mk(31, c);
            in_im    = ~mk(31, c);
            tick();
        end
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        sb.delete();
        in_cnt    = 0;
        hold_prev = 1'b0;
        check_reset_outputs();
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        drive_frame(40, 100, low, pre);
        in_valid = 1'b0;
        check("post_rst_valid", out_valid, 1);
        wait_drain("post_rst_drain");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
